// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized serial input, mid-bit sampling of start/data/stop,
// byte delivered on a valid/ready handshake with one-cycle frame-error and overrun pulses.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 9600,
    parameter int CLK_FREQ   = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sig,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  frame_err,
    output logic                  overrun
);
    localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W       = $clog2(PULSE_WIDTH) + 1;
    localparam int IDX_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(PULSE_WIDTH / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic                    sync1_q, rs_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    overrun_q, overrun_d;
    logic                    good_s;

    // State, synchronizer and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q     <= 1'b1;
            rs_q        <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sig;
            rs_q        <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Frame recovery state machine and output handshake next-state
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        good_s      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rs_q) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A start bit that is high again at mid-bit was only a glitch.
                    if (rs_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rs_q, shift_q[DATA_WIDTH-1:1]};
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (rs_q) begin
                        good_s  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
                cnt_d = '0;
                if (rs_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        // A load in the same cycle as a consume keeps valid high with the new byte.
        if (good_s) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives serial frames and scoreboards the handshake output.
module tb_uart_rx;
    localparam int CF   = 120;
    localparam int BR   = 10;
    localparam int PW   = CF / BR;
    localparam int HALF = PW / 2;
    localparam int LAT_LO = 9 * PW + HALF + 1;
    localparam int LAT_HI = 9 * PW + HALF + 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic       sig;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    int ferr_seen = 0, ovr_seen = 0, exp_ferr = 0, exp_ovr = 0;
    int pulse_bad = 0, hs_bad = 0;
    int run_len = 0, last_run = 0, last_rise = 0;
    logic       prev_v = 1'b0, prev_r = 1'b0, prev_fe = 1'b0, prev_ov = 1'b0;
    logic [7:0] prev_d = 8'h00;

    uart_rx #(.DATA_WIDTH(8), .BAUD_RATE(BR), .CLK_FREQ(CF)) dut (
        .clk(clk), .rstn(rstn), .sig(sig), .data(data), .valid(valid),
        .ready(ready), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: scoreboard handshakes, count pulses, police pulse width and hold rules
    always @(negedge clk) begin
        if (!rstn) begin
            prev_v  <= 1'b0;
            prev_fe <= 1'b0;
            prev_ov <= 1'b0;
            run_len <= 0;
        end else begin
            if (frame_err) ferr_seen <= ferr_seen + 1;
            if (overrun)   ovr_seen  <= ovr_seen + 1;
            if ((frame_err && prev_fe) || (overrun && prev_ov) || (frame_err && overrun))
                pulse_bad <= pulse_bad + 1;
            if (prev_v && !prev_r && (!valid || data != prev_d))
                hs_bad <= hs_bad + 1;
            if (valid && !prev_v) last_rise <= cyc;
            if (valid) begin
                run_len <= run_len + 1;
            end else if (run_len > 0) begin
                last_run <= run_len;
                run_len  <= 0;
            end
            if (valid && ready) begin
                if (exp_q.size() == 0) check_eq("unexpected_byte", {24'd0, data}, 32'hFFFF_FFFF);
                else                   check_eq("rx_byte", {24'd0, data}, {24'd0, exp_q.pop_front()});
            end
            prev_v  <= valid;
            prev_r  <= ready;
            prev_d  <= data;
            prev_fe <= frame_err;
            prev_ov <= overrun;
        end
    end

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic v, input int n);
        sig = v;
        repeat (n) tick1();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        hold(1'b0, PW);
        for (int i = 0; i < 8; i++) hold(b[i], PW);
        hold(stop_bit, PW);
    endtask

    task automatic phase_end(input string tag);
        hold(1'b1, 2 * PW);
        check_eq({tag, "_pending"}, exp_q.size(), 0);
        check_eq({tag, "_ferr"}, ferr_seen, exp_ferr);
        check_eq({tag, "_ovr"}, ovr_seen, exp_ovr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic [7:0] b;
        logic bad;
        int gap;

        rstn  = 1'b0;
        sig   = 1'b1;
        ready = 1'b1;
        repeat (3) tick1();
        check_eq("rst_data", {24'd0, data}, 32'd0);
        check_eq("rst_valid", valid, 1'b0);
        check_eq("rst_ferr", frame_err, 1'b0);
        check_eq("rst_ovr", overrun, 1'b0);
        rstn = 1'b1;
        hold(1'b1, 2 * PW);

        // Single frame: latency and one-cycle valid with ready high
        t0 = cyc;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        phase_end("a5");
        check_eq("a5_latency_in_window",
                 ((last_rise - t0) >= LAT_LO) && ((last_rise - t0) <= LAT_HI), 1'b1);
        check_eq("a5_valid_width", last_run, 1);

        // Back-to-back sweep of every byte value
        for (int v = 0; v < 256; v++) begin
            exp_q.push_back(8'(v));
            send_frame(8'(v), 1'b1);
        end
        phase_end("sweep");

        // Short low glitch is rejected, next frame still received
        hold(1'b0, HALF / 2);
        hold(1'b1, 2 * PW);
        check_eq("glitch_no_valid", valid, 1'b0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        phase_end("glitch");

        // Bad stop bit followed by a break, then a good frame
        send_frame(8'h3C, 1'b0);
        exp_ferr++;
        hold(1'b0, 3 * PW);
        hold(1'b1, PW);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        phase_end("ferr");

        // Overrun: second byte dropped while the first is still held
        ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        exp_ovr++;
        hold(1'b1, 2 * PW);
        check_eq("ovr_valid_held", valid, 1'b1);
        check_eq("ovr_data_held", {24'd0, data}, 32'h11);
        check_eq("ovr_count", ovr_seen, exp_ovr);
        ready = 1'b1;
        tick1();
        tick1();
        check_eq("ovr_valid_fall", valid, 1'b0);
        phase_end("ovr");

        // Reset in the middle of a data bit
        hold(1'b0, PW);
        hold(1'b1, PW);
        hold(1'b1, PW);
        hold(1'b1, PW / 2);
        rstn = 1'b0;
        sig  = 1'b1;
        tick1();
        check_eq("midrst_data", {24'd0, data}, 32'd0);
        check_eq("midrst_valid", valid, 1'b0);
        check_eq("midrst_ferr", frame_err, 1'b0);
        check_eq("midrst_ovr", overrun, 1'b0);
        repeat (9) tick1();
        rstn = 1'b1;
        hold(1'b1, 2 * PW);
        exp_q.push_back(8'h88);
        send_frame(8'h88, 1'b1);
        phase_end("midrst");

        // Random frames with occasional bad stop bits and random idle gaps
        for (int n = 0; n < 40; n++) begin
            b   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 7) == 0);
            if (bad) exp_ferr++;
            else     exp_q.push_back(b);
            send_frame(b, !bad);
            gap = bad ? 1 + $urandom_range(0, 1) : $urandom_range(0, 2);
            if (gap > 0) hold(1'b1, gap * PW);
        end
        phase_end("random");

        check_eq("pulse_rules", pulse_bad, 0);
        check_eq("handshake_hold", hs_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
